// File: rtl/button_in.sv
// ----------------------------------------------------------------------------
// button_in
//
// Debounced pushbutton input conditioner. A raw, asynchronous board button
// pin is brought into the in_clock domain through a two-flop synchronizer,
// optionally inverted for pull-up buttons, and then qualified by a four-state
// FSM with a stability counter. A new level is accepted only after it has
// been seen for DEBOUNCE consecutive cycles. The core receives a clean level,
// one-cycle press/release strobes, and an optional 8-bit press counter.
//
// Parameters
//   DEBOUNCE   : consecutive stable cycles needed to accept a level (1..65535)
//   CNT_W      : width of the qualification counter, DEBOUNCE-1 < 2**CNT_W
//   ACTIVE_LOW : 1 inverts the synchronized pin (button reads 0 when pressed)
//
// Ports
//   in_clock    : the only clock, rising edge
//   in_reset    : asynchronous, active-high reset
//   in_button   : raw asynchronous button pin
//   out_level   : debounced level, 1 = pressed
//   out_press   : one-cycle strobe on each accepted press
//   out_release : one-cycle strobe on each accepted release
//   out_count   : accepted presses modulo 256
//
// Build option
//   BUTTON_IN_COUNT_EN : when defined, the press counter is built and drives
//                        out_count; otherwise out_count is tied to 8'h00.
// ----------------------------------------------------------------------------
module button_in #(
    parameter int DEBOUNCE   = 24000,
    parameter int CNT_W      = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_button,
    output logic       out_level,
    output logic       out_press,
    output logic       out_release,
    output logic [7:0] out_count
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    // Synchronizer
    logic s1_q;
    logic s1_d;
    logic s2_q;
    logic s2_d;
    logic b;

    // Qualification FSM
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Registered outputs
    logic level_q;
    logic level_d;
    logic press_q;
    logic press_d;
    logic release_q;
    logic release_d;

    // ------------------------------------------------------------------
    // Stage 0: two-flop synchronizer; polarity is fixed after s2 so the
    // metastability-hardened flop always sees the raw pin.
    // ------------------------------------------------------------------
    always_comb begin
        s1_d = in_button;
        s2_d = s1_q;
    end

    assign b = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;

    // ------------------------------------------------------------------
    // Stage 1: qualification FSM. Each WAIT state counts stable cycles of
    // the candidate level; any opposite sample falls back to the stable
    // state it came from without touching the outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            RELEASED: begin
                if (b) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!b) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!b) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (b) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase

        // The level follows the state being entered so it changes on the
        // same edge as the accepting strobe.
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign out_level   = level_q;
    assign out_press   = press_q;
    assign out_release = release_q;

    // ------------------------------------------------------------------
    // Stage 2: optional press counter, advancing on the same edge that
    // raises out_press.
    // ------------------------------------------------------------------
`ifdef BUTTON_IN_COUNT_EN
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (press_d) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            count_q <= 8'h00;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`else
    assign out_count = 8'h00;
`endif

endmodule

// File: tb/tb_button_in.sv
// ----------------------------------------------------------------------------
// tb_button_in
//
// Directed bench for button_in with DEBOUNCE=4. Two instances share clock and
// reset: u_dut (ACTIVE_LOW=0) and u_al (ACTIVE_LOW=1). Inputs are driven and
// outputs sampled on the falling edge; after the k-th rising edge following a
// pin change the outputs reflect the state entered at edge k.
// ----------------------------------------------------------------------------
module tb_button_in;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       btn_al;
    logic       lvl, prs, rel;
    logic [7:0] cnt;
    logic       lvl_al, prs_al, rel_al;
    logic [7:0] cnt_al;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int exp_cnt_al = 0;

    button_in #(.DEBOUNCE(4), .CNT_W(16), .ACTIVE_LOW(0)) u_dut (
        .in_clock    (clk),
        .in_reset    (rst),
        .in_button   (btn),
        .out_level   (lvl),
        .out_press   (prs),
        .out_release (rel),
        .out_count   (cnt)
    );

    button_in #(.DEBOUNCE(4), .CNT_W(16), .ACTIVE_LOW(1)) u_al (
        .in_clock    (clk),
        .in_reset    (rst),
        .in_button   (btn_al),
        .out_level   (lvl_al),
        .out_press   (prs_al),
        .out_release (rel_al),
        .out_count   (cnt_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] count_of(input int n);
`ifdef BUTTON_IN_COUNT_EN
        return 8'(n % 256);
`else
        return 8'h00;
`endif
    endfunction

    task automatic test_reset();
        logic [2:0] exp3;
        rst = 1'b1;
        btn = 1'b0;
        btn_al = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({lvl, prs, rel, cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_main: got lpr=%b cnt=%0d want 000 cnt=0", {lvl, prs, rel}, cnt);
        end
        checks++;
        if ({lvl_al, prs_al, rel_al, cnt_al} !== 11'd0) begin
            errors++;
            $display("FAIL reset_al: got lpr=%b cnt=%0d want 000 cnt=0", {lvl_al, prs_al, rel_al}, cnt_al);
        end
        rst = 1'b0;
        exp3 = 3'b000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if ({lvl, prs, rel} !== exp3 || cnt !== 8'd0) begin
                errors++;
                $display("FAIL idle k=%0d: got lpr=%b cnt=%0d want 000 cnt=0", k, {lvl, prs, rel}, cnt);
            end
            checks++;
            if ({lvl_al, prs_al, rel_al} !== exp3 || cnt_al !== 8'd0) begin
                errors++;
                $display("FAIL idle_al k=%0d: got lpr=%b cnt=%0d want 000 cnt=0", k, {lvl_al, prs_al, rel_al}, cnt_al);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] exp3;
        btn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 7) exp_cnt++;
            exp3 = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({lvl, prs, rel} !== exp3) begin
                errors++;
                $display("FAIL press k=%0d: got lpr=%b want %b", k, {lvl, prs, rel}, exp3);
            end
            checks++;
            if (cnt !== count_of(exp_cnt)) begin
                errors++;
                $display("FAIL press_count k=%0d: got %0d want %0d", k, cnt, count_of(exp_cnt));
            end
        end
    endtask

    task automatic test_clean_release();
        logic [2:0] exp3;
        btn = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp3 = {k < 7, 1'b0, k == 7};
            checks++;
            if ({lvl, prs, rel} !== exp3) begin
                errors++;
                $display("FAIL release k=%0d: got lpr=%b want %b", k, {lvl, prs, rel}, exp3);
            end
            checks++;
            if (cnt !== count_of(exp_cnt)) begin
                errors++;
                $display("FAIL release_count k=%0d: got %0d want %0d", k, cnt, count_of(exp_cnt));
            end
        end
    endtask

    task automatic test_bounce();
        logic [16:0] pat;
        logic [2:0]  exp3;
        // Applied LSB first: 1,1,0,1,1,1 then zeros to let it settle.
        pat = 17'b00000000000111011;
        for (int k = 0; k < 17; k++) begin
            btn = pat[k];
            @(negedge clk);
            checks++;
            if ({lvl, prs, rel} !== 3'b000) begin
                errors++;
                $display("FAIL bounce k=%0d: got lpr=%b want 000", k, {lvl, prs, rel});
            end
        end
        btn = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 7) exp_cnt++;
            exp3 = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({lvl, prs, rel} !== exp3) begin
                errors++;
                $display("FAIL bounce_press k=%0d: got lpr=%b want %b", k, {lvl, prs, rel}, exp3);
            end
        end
        checks++;
        if (cnt !== count_of(exp_cnt)) begin
            errors++;
            $display("FAIL bounce_count: got %0d want %0d", cnt, count_of(exp_cnt));
        end
    endtask

    task automatic test_wrap();
        int start;
        start = exp_cnt;
        for (int i = start; i < 256; i++) begin
            btn = 1'b1;
            repeat (7) @(negedge clk);
            exp_cnt++;
            checks++;
            if ({lvl, prs} !== 2'b11 || cnt !== count_of(exp_cnt)) begin
                errors++;
                $display("FAIL wrap i=%0d: got lp=%b cnt=%0d want 11 cnt=%0d", i, {lvl, prs}, cnt, count_of(exp_cnt));
            end
            @(negedge clk);
            btn = 1'b0;
            repeat (8) @(negedge clk);
        end
        checks++;
        if (cnt !== 8'd0 || lvl !== 1'b0) begin
            errors++;
            $display("FAIL wrap_final: got cnt=%0d lvl=%b want cnt=0 lvl=0", cnt, lvl);
        end
    endtask

    task automatic test_active_low();
        logic [2:0] exp3;
        btn_al = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 7) exp_cnt_al++;
            exp3 = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({lvl_al, prs_al, rel_al} !== exp3) begin
                errors++;
                $display("FAIL al_press k=%0d: got lpr=%b want %b", k, {lvl_al, prs_al, rel_al}, exp3);
            end
        end
        checks++;
        if (cnt_al !== count_of(exp_cnt_al)) begin
            errors++;
            $display("FAIL al_count: got %0d want %0d", cnt_al, count_of(exp_cnt_al));
        end
        btn_al = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp3 = {k < 7, 1'b0, k == 7};
            checks++;
            if ({lvl_al, prs_al, rel_al} !== exp3) begin
                errors++;
                $display("FAIL al_release k=%0d: got lpr=%b want %b", k, {lvl_al, prs_al, rel_al}, exp3);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp3;
        // Reset while PRESSED with a nonzero counter.
        btn = 1'b1;
        repeat (8) @(negedge clk);
        exp_cnt++;
        checks++;
        if (lvl !== 1'b1 || cnt !== count_of(exp_cnt)) begin
            errors++;
            $display("FAIL pre_reset: got lvl=%b cnt=%0d want lvl=1 cnt=%0d", lvl, cnt, count_of(exp_cnt));
        end
        #2 rst = 1'b1;
        #1;
        exp_cnt = 0;
        checks++;
        if ({lvl, prs, rel, cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_pressed: got lpr=%b cnt=%0d want 000 cnt=0", {lvl, prs, rel}, cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        // Pin held; pulse reset right after edge 5 (mid PRESS_WAIT).
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({lvl, prs, rel, cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_wait: got lpr=%b cnt=%0d want 000 cnt=0", {lvl, prs, rel}, cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 7) exp_cnt++;
            exp3 = {k >= 7, k == 7, 1'b0};
            checks++;
            if ({lvl, prs, rel} !== exp3) begin
                errors++;
                $display("FAIL requal k=%0d: got lpr=%b want %b", k, {lvl, prs, rel}, exp3);
            end
        end
        checks++;
        if (cnt !== count_of(exp_cnt)) begin
            errors++;
            $display("FAIL requal_count: got %0d want %0d", cnt, count_of(exp_cnt));
        end
    endtask

    initial begin
        test_reset();
        test_active_low();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_clean_release();
        test_wrap();
        test_reset_mid();
        test_clean_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_in.md
# button_in

Debounced pushbutton input conditioner for the FPGA LED/core top levels: the input-side counterpart to the LED output path. It synchronizes a raw board button pin into the `in_clock` domain, filters contact bounce with a qualification counter and a four-state FSM, and presents a clean level, one-cycle press/release strobes and an optional press counter to the core. It sits between the board pin and the core's input port, alongside the power-on reset counter in the top-level wrapper.

## Interface
- `DEBOUNCE`, default 24000 — consecutive stable cycles required to accept a new level (1 ms at 24 MHz); legal range 1..65535.
- `CNT_W`, default 16 — debounce counter width; must satisfy `DEBOUNCE-1 < 2**CNT_W`.
- `ACTIVE_LOW`, default 0 — 1 inverts the pin after synchronization; use it for pull-up buttons that read 0 when pressed.
- `in_clock` input 1 — the only clock, rising edge.
- `in_reset` input 1 — asynchronous, active-high reset.
- `in_button` input 1 — raw asynchronous button pin.
- `out_level` output 1 — debounced level; 1 means pressed.
- `out_press` output 1 — one-cycle strobe on each accepted press.
- `out_release` output 1 — one-cycle strobe on each accepted release.
- `out_count` output 8 — number of accepted presses, modulo 256.

## Operation
- Synchronizer: two flops `s1` and `s2`, both reset to 0. `ACTIVE_LOW` inversion is applied to `s2`, giving the signal `b`.
- FSM states and transitions:
  - RELEASED: if `b` is 1, go to PRESS_WAIT and set cnt to 0.
  - PRESS_WAIT:
    - If `b` is 0, return to RELEASED; this is a bounce.
    - Else if cnt equals `DEBOUNCE-1`, go to PRESSED.
    - Otherwise increment cnt.
  - PRESSED: if `b` is 0, go to RELEASE_WAIT and set cnt to 0.
  - RELEASE_WAIT: mirror of PRESS_WAIT with `b` inverted. On qualification it goes to RELEASED; if `b` returns to 1 it goes back to PRESSED.
- All outputs are registered.
  - `out_level` is 1 exactly while the FSM is in PRESSED or RELEASE_WAIT.
  - `out_press` is 1 for the single cycle in which PRESS_WAIT transitions to PRESSED.
  - `out_release` is 1 for the single cycle in which RELEASE_WAIT transitions to RELEASED.
- `out_press` and `out_release` are never asserted together.
- A bounce inside a WAIT state produces no strobe and no change in `out_level`.
- `out_count` increments by 1 in the cycle `out_press` asserts, and wraps from 255 to 0.
- cnt never exceeds `DEBOUNCE-1`. With `DEBOUNCE`=1, each WAIT state lasts exactly one cycle.

## Timing
- Reset values:
  - `out_level`, `out_press`, `out_release` and `out_count` are 0.
  - FSM is in RELEASED, cnt is 0, `s1` and `s2` are 0.
  - With `ACTIVE_LOW`=1, a released pin (1) yields `b`=0, so no spurious press occurs after reset.
- Latency: number edges from the first rising edge that samples the new stable pin level as edge 1.
  - Edge 2 updates `s2`.
  - Edge 3 enters the WAIT state with cnt 0.
  - Edge `DEBOUNCE+3` enters the accepting state; `out_level` and the strobe are updated at this edge.
  - Release latency is the same.
- Reset mid-operation (any state, including a WAIT state with cnt partially counted) immediately returns the block to reset values.
  - After reset deassertion, a pin held pressed is re-qualified from RELEASED with the full latency.
  - Reset clears `out_count`.
- A pin glitch shorter than `DEBOUNCE` cycles, as seen at `s2`, never changes `out_level`.

## Configuration
- `BUTTON_IN_COUNT_EN` defined: the 8-bit press counter is built and drives `out_count` as described.
- Macro undefined: no counter register; `out_count` is tied to 8'h00. All other behaviour is identical.

## Test plan
All scenarios use `DEBOUNCE`=4 and `ACTIVE_LOW`=0 unless stated.
- Reset then idle: `in_button`=0 for 20 cycles -> `out_level`=0, no strobes, `out_count`=0.
- Clean press: `in_button` goes to 1 before edge 1 and is held -> `out_level` rises at edge 7; `out_press`=1 only in the cycle after edge 7; `out_count`=1.
- Bounce: 1 for 2 cycles, 0 for 1 cycle, 1 for 3 cycles, then 0 -> `out_level` stays 0, no `out_press`. Then hold 1 -> press accepted 7 edges after the final rise.
- Clean release after a press: `in_button` set to 0 and held -> `out_level` falls at edge 7; a single `out_release` pulse; `out_count` unchanged.
- Wrap and configuration:
  - 256 qualified presses -> `out_count` returns to 0.
  - Same test with the macro undefined -> `out_count`=0 throughout.
  - `ACTIVE_LOW`=1 with pin idle at 1 -> no press; pin driven to 0 -> press at edge 7.
- Reset mid-PRESS_WAIT (pulse `in_reset` at edge 5 with pin held at 1) -> outputs are 0 immediately; after deassertion, `out_level` rises `DEBOUNCE+3` edges later.
